// File: rtl/iir_coef_ctrl_pkg.sv
// iir_coef_ctrl_pkg
// Shared constants and types for the IIR coefficient controller:
// coefficient width and layout, coefficient index codes, FSM state encoding.
package iir_coef_ctrl_pkg;

   localparam int COEF_W        = 16;
   localparam int COEFS_PER_SEC = 4;
   localparam int SEC_BITS      = COEF_W * COEFS_PER_SEC;

   localparam logic [1:0] IDX_A11 = 2'd0;
   localparam logic [1:0] IDX_A21 = 2'd1;
   localparam logic [1:0] IDX_B11 = 2'd2;
   localparam logic [1:0] IDX_B21 = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_STB = 2'd1,
      FLUSH    = 2'd2
   } state_t;

endpackage

// File: rtl/iir_coef_ctrl_bank.sv
// iir_coef_bank
// Shadow and active coefficient banks for NSEC biquad sections.
//   clk, reset  : clock, synchronous active-low reset (zeroes both banks)
//   we          : write one shadow coefficient at (wsec, widx) with wdata
//   copy        : bulk-copy the whole shadow bank into the active bank
//   coef_out    : flattened active bank, section s at [64s+63:64s],
//                 {b_2_1, b_1_1, a_2_1, a_1_1} with a_1_1 in the low bits
// The caller guarantees wsec < NSEC and that we/copy are never asserted
// together, so no ordering between the two paths is needed.
module iir_coef_bank
   import iir_coef_ctrl_pkg::*;
#(
   parameter int NSEC = 2,
   parameter int SECW = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [SECW-1:0]          wsec,
   input  logic [1:0]               widx,
   input  logic [COEF_W-1:0]        wdata,
   input  logic                     copy,
   output logic [NSEC*SEC_BITS-1:0] coef_out
);

   logic [NSEC*SEC_BITS-1:0] shadow;
   logic [NSEC*SEC_BITS-1:0] active;

   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow <= '0;
         active <= '0;
      end else begin
         if (copy) begin
            active <= shadow;
         end
         if (we) begin
            for (int s = 0; s < NSEC; s++) begin
               for (int i = 0; i < COEFS_PER_SEC; i++) begin
                  if (wsec == SECW'(s) && widx == 2'(i)) begin
                     shadow[(s*COEFS_PER_SEC + i)*COEF_W +: COEF_W] <= wdata;
                  end
               end
            end
         end
      end
   end

   assign coef_out = active;

endmodule

// File: rtl/iir_coef_ctrl.sv
// iir_coef_ctrl
// Coefficient configuration controller for a cascade of NSEC IIR sections.
// Host writes land in a shadow bank; a commit swaps shadow into active on
// the next sample strobe, optionally followed by a delay-line flush.
//   clk, reset          : clock, synchronous active-low reset
//   cfg_we/sec/idx/wdata: single coefficient write into the shadow bank
//   cfg_commit, cfg_flush: request a swap, flush flag sampled with it
//   sample_en           : datapath sample strobe (swap boundary)
//   coef_out            : active coefficients, flattened
//   sec_reset_n         : registered active-low reset to all sections
//   busy                : commit in progress
//   commit_done         : one-cycle pulse when a commit finishes
//   cfg_err             : one-cycle pulse when a write/commit was rejected
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting writes and commits
// WAIT_STB | commit pending, waiting for sample_en to swap banks
// FLUSH    | banks swapped, holding sec_reset_n low for FLUSH_CYC cycles
module iir_coef_ctrl
   import iir_coef_ctrl_pkg::*;
#(
   parameter int NSEC      = 2,
   parameter int SECW      = 1,
   parameter int FLUSH_CYC = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_we,
   input  logic [SECW-1:0]          cfg_sec,
   input  logic [1:0]               cfg_idx,
   input  logic [COEF_W-1:0]        cfg_wdata,
   input  logic                     cfg_commit,
   input  logic                     cfg_flush,
   input  logic                     sample_en,
   output logic [NSEC*SEC_BITS-1:0] coef_out,
   output logic                     sec_reset_n,
   output logic                     busy,
   output logic                     commit_done,
   output logic                     cfg_err
);

   localparam int              CNT_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(FLUSH_CYC - 1);
   localparam logic [SECW:0]   NSEC_L = (SECW+1)'(NSEC);

   state_t           state;
   logic             flush_q;
   logic [CNT_W-1:0] cnt;

   logic sec_ok;
   logic idle;
   logic write_ok;
   logic copy;
   logic err_now;

   assign sec_ok   = ({1'b0, cfg_sec} < NSEC_L);
   assign idle     = (state == IDLE);
   assign write_ok = cfg_we && sec_ok && idle;
   assign copy     = (state == WAIT_STB) && sample_en;
   assign err_now  = (cfg_we && (!sec_ok || !idle)) || (cfg_commit && !idle);

   iir_coef_bank #(
      .NSEC (NSEC),
      .SECW (SECW)
   ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .we       (write_ok),
      .wsec     (cfg_sec),
      .widx     (cfg_idx),
      .wdata    (cfg_wdata),
      .copy     (copy),
      .coef_out (coef_out)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         flush_q     <= 1'b0;
         cnt         <= '0;
         busy        <= 1'b0;
         commit_done <= 1'b0;
         cfg_err     <= 1'b0;
         sec_reset_n <= 1'b0;
      end else begin
         commit_done <= 1'b0;
         cfg_err     <= err_now;
         sec_reset_n <= 1'b1;
         case (state)
            IDLE: begin
               // sample_en in this same cycle is deliberately not a swap point
               if (cfg_commit) begin
                  flush_q <= cfg_flush;
                  state   <= WAIT_STB;
                  busy    <= 1'b1;
               end
            end
            WAIT_STB: begin
               if (sample_en) begin
                  if (flush_q) begin
                     state       <= FLUSH;
                     sec_reset_n <= 1'b0;
                     cnt         <= CNT_LD;
                  end else begin
                     state       <= IDLE;
                     busy        <= 1'b0;
                     commit_done <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (cnt == '0) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  commit_done <= 1'b1;
               end else begin
                  cnt         <= cnt - 1'b1;
                  sec_reset_n <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
module tb_iir_coef_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_we;
   logic [0:0]   cfg_sec;
   logic [1:0]   cfg_idx;
   logic [15:0]  cfg_wdata;
   logic         cfg_commit;
   logic         cfg_flush;
   logic         sample_en;
   logic [127:0] coef_out;
   logic         sec_reset_n;
   logic         busy;
   logic         commit_done;
   logic         cfg_err;

   logic [63:0]  one_coef_out;
   logic         one_sec_reset_n;
   logic         one_busy;
   logic         one_commit_done;
   logic         one_cfg_err;

   int checks = 0;
   int errors = 0;

   logic [127:0] model_sh;
   logic [127:0] model_act;
   logic [63:0]  one_sh;
   logic [63:0]  one_act;
   logic [127:0] exp_q[$];
   logic [63:0]  one_q[$];
   logic [127:0] exp_v;

   always #5 clk = ~clk;

   iir_coef_ctrl #(.NSEC(2), .SECW(1), .FLUSH_CYC(3)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sec(cfg_sec), .cfg_idx(cfg_idx),
      .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_flush(cfg_flush),
      .sample_en(sample_en), .coef_out(coef_out), .sec_reset_n(sec_reset_n),
      .busy(busy), .commit_done(commit_done), .cfg_err(cfg_err)
   );

   // single-section instance for out-of-range section rejects
   iir_coef_ctrl #(.NSEC(1), .SECW(1), .FLUSH_CYC(3)) u_one (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sec(cfg_sec), .cfg_idx(cfg_idx),
      .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_flush(cfg_flush),
      .sample_en(sample_en), .coef_out(one_coef_out), .sec_reset_n(one_sec_reset_n),
      .busy(one_busy), .commit_done(one_commit_done), .cfg_err(one_cfg_err)
   );

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_write(input int sec, input int idx, input logic [15:0] d);
      if (sec < 2) model_sh[(sec*4+idx)*16 +: 16] = d;
      if (sec == 0) one_sh[idx*16 +: 16] = d;
   endtask

   task automatic do_write(input int sec, input int idx, input logic [15:0] d);
      cfg_we = 1'b1; cfg_sec = 1'(sec); cfg_idx = 2'(idx); cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
      model_write(sec, idx, d);
   endtask

   task automatic do_commit(input logic fl);
      cfg_commit = 1'b1; cfg_flush = fl;
      tick();
      cfg_commit = 1'b0; cfg_flush = 1'b0;
      exp_q.push_back(model_sh);
      one_q.push_back(one_sh);
   endtask

   task automatic do_strobe();
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
   endtask

   // pop the expected active bank when a commit completes and compare
   task automatic score_done();
      checks++;
      if (exp_q.size() == 0 || one_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard empty at commit_done");
      end else begin
         model_act = exp_q.pop_front();
         one_act   = one_q.pop_front();
         if (coef_out !== model_act) begin
            errors++;
            $display("FAIL coef_after_commit got %h exp %h", coef_out, model_act);
         end
         checks++;
         if (one_coef_out !== one_act) begin
            errors++;
            $display("FAIL one_coef_after_commit got %h exp %h", one_coef_out, one_act);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (sec_reset_n !== 1'b0) begin errors++; $display("FAIL rst_sec_reset_n_low got %b exp 0", sec_reset_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      reset = 1'b1;
      tick();
      checks++; if (sec_reset_n !== 1'b1) begin errors++; $display("FAIL rel_sec_reset_n got %b exp 1", sec_reset_n); end
      checks++; if (coef_out !== 128'h0) begin errors++; $display("FAIL rel_coef got %h exp 0", coef_out); end
      checks++; if (busy !== 1'b0 || commit_done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL rel_flags got %b%b%b exp 000", busy, commit_done, cfg_err); end
   endtask

   task automatic test_commit();
      do_write(0, 0, 16'h1234);
      do_write(1, 3, 16'hABCD);
      checks++; if (coef_out !== model_act) begin errors++; $display("FAIL shadow_isolated got %h exp %h", coef_out, model_act); end
      do_commit(1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy got %b exp 1", busy); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (coef_out !== model_act || commit_done !== 1'b0) begin errors++; $display("FAIL wait_stb_hold got %h/%b exp %h/0", coef_out, commit_done, model_act); end
      end
      do_strobe();
      checks++; if (commit_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL commit_done_busy got %b/%b exp 1/0", commit_done, busy); end
      checks++; if (coef_out[15:0] !== 16'h1234 || coef_out[127:112] !== 16'hABCD) begin errors++; $display("FAIL commit_fields got %h/%h exp 1234/abcd", coef_out[15:0], coef_out[127:112]); end
      score_done();
      tick();
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL commit_done_single got %b exp 0", commit_done); end
   endtask

   task automatic test_flush();
      do_write(1, 0, 16'h5555);
      do_commit(1'b1);
      tick(); tick();
      do_strobe();
      exp_v = exp_q[0];
      checks++; if (coef_out !== exp_v) begin errors++; $display("FAIL flush_swap got %h exp %h", coef_out, exp_v); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (sec_reset_n !== 1'b0 || commit_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_low_%0d got %b%b%b exp 001", i, sec_reset_n, commit_done, busy); end
         tick();
      end
      checks++; if (sec_reset_n !== 1'b1 || commit_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_end got %b%b%b exp 110", sec_reset_n, commit_done, busy); end
      score_done();
      tick();
      checks++; if (commit_done !== 1'b0 || sec_reset_n !== 1'b1) begin errors++; $display("FAIL flush_after got %b/%b exp 0/1", commit_done, sec_reset_n); end
   endtask

   task automatic test_rejects();
      do_write(1, 0, 16'hBEEF);
      checks++; if (one_cfg_err !== 1'b1) begin errors++; $display("FAIL oob_err got %b exp 1", one_cfg_err); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL inrange_no_err got %b exp 0", cfg_err); end
      tick();
      checks++; if (one_cfg_err !== 1'b0) begin errors++; $display("FAIL oob_err_single got %b exp 0", one_cfg_err); end
      do_commit(1'b0);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL busy_commit_err got %b exp 1", cfg_err); end
      tick();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL busy_commit_err_single got %b exp 0", cfg_err); end
      cfg_we = 1'b1; cfg_sec = 1'b0; cfg_idx = 2'd1; cfg_wdata = 16'h7777;
      tick();
      cfg_we = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL busy_write_err got %b exp 1", cfg_err); end
      tick();
      checks++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL busy_write_after got %b/%b exp 0/1", cfg_err, busy); end
      do_strobe();
      checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL reject_commit_done got %b exp 1", commit_done); end
      score_done();
      tick();
   endtask

   task automatic test_same_cycle();
      cfg_we = 1'b1; cfg_sec = 1'b0; cfg_idx = 2'd2; cfg_wdata = 16'h00FF;
      cfg_commit = 1'b1; sample_en = 1'b1;
      tick();
      cfg_we = 1'b0; cfg_commit = 1'b0; sample_en = 1'b0;
      model_write(0, 2, 16'h00FF);
      exp_q.push_back(model_sh);
      one_q.push_back(one_sh);
      checks++; if (coef_out !== model_act || busy !== 1'b1) begin errors++; $display("FAIL same_no_swap got %h/%b exp %h/1", coef_out, busy, model_act); end
      tick();
      checks++; if (commit_done !== 1'b0 || coef_out !== model_act) begin errors++; $display("FAIL same_still_waiting got %b/%h exp 0/%h", commit_done, coef_out, model_act); end
      do_strobe();
      checks++; if (commit_done !== 1'b1 || coef_out[47:32] !== 16'h00FF) begin errors++; $display("FAIL same_swap got %b/%h exp 1/00ff", commit_done, coef_out[47:32]); end
      score_done();
      tick();
   endtask

   task automatic test_reset_mid_flush();
      do_write(0, 3, 16'hC0DE);
      do_commit(1'b1);
      do_strobe();
      tick();
      reset = 1'b0;
      tick();
      exp_q.delete(); one_q.delete();
      model_sh = '0; model_act = '0; one_sh = '0; one_act = '0;
      checks++; if (coef_out !== 128'h0 || commit_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got %h/%b/%b exp 0/0/0", coef_out, commit_done, busy); end
      reset = 1'b1;
      tick();
      checks++; if (sec_reset_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_release got %b/%b exp 1/0", sec_reset_n, busy); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL mid_no_done_%0d got %b exp 0", i, commit_done); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      do_write(1, 1, 16'h4242);
      do_commit(1'b0);
      do_strobe();
      checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL b2b_first got %b exp 1", commit_done); end
      score_done();
      do_write(0, 1, 16'h9999);
      do_commit(1'b1);
      do_strobe();
      tick(); tick(); tick();
      checks++; if (commit_done !== 1'b1 || sec_reset_n !== 1'b1) begin errors++; $display("FAIL b2b_second got %b/%b exp 1/1", commit_done, sec_reset_n); end
      score_done();
      tick();
   endtask

   initial begin
      reset = 1'b0; cfg_we = 1'b0; cfg_sec = '0; cfg_idx = '0; cfg_wdata = '0;
      cfg_commit = 1'b0; cfg_flush = 1'b0; sample_en = 1'b0;
      model_sh = '0; model_act = '0; one_sh = '0; one_act = '0;
      #1;
      test_reset();
      test_commit();
      test_flush();
      test_rejects();
      test_same_cycle();
      test_reset_mid_flush();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iir_coef_ctrl.md
Name: iir_coef_ctrl

Overview:
- Configuration controller for a cascade of NSEC second-order IIR sections.
- Each section takes four 16-bit coefficients: a_1_1, a_2_1, b_1_1, b_2_1.
- Host writes go into a shadow bank. A commit copies shadow to active only on a sample-strobe boundary, so coefficients never change mid-sample.
- Optionally clears the sections' delay lines after the swap by pulsing their active-low reset.

Parameters:
- NSEC, 2, number of IIR sections served.
- SECW, 1, width of section select (≥ clog2(NSEC), min 1).
- FLUSH_CYC, 3, cycles sec_reset_n is held low on a flushing commit (≥ 1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cfg_we  in  1  write strobe for one coefficient.
- cfg_sec  in  SECW  target section.
- cfg_idx  in  2  coefficient select: 0=a_1_1, 1=a_2_1, 2=b_1_1, 3=b_2_1.
- cfg_wdata  in  16  coefficient value.
- cfg_commit  in  1  request shadow→active swap.
- cfg_flush  in  1  sampled with cfg_commit; 1 = flush sections after swap.
- sample_en  in  1  one-cycle sample strobe from the datapath.
- coef_out  out  NSEC*64  active coefficients. Section s occupies [64s+63:64s] as {b_2_1, b_1_1, a_2_1, a_1_1}, a_1_1 in the low 16 bits.
- sec_reset_n  out  1  active-low synchronous reset driven to all sections.
- busy  out  1  commit in progress.
- commit_done  out  1  one-cycle pulse when the commit completes.
- cfg_err  out  1  one-cycle pulse when a write or commit is rejected.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Outputs while reset=0: shadow=0, active=0, state=IDLE, busy=0, commit_done=0, cfg_err=0, sec_reset_n=0.
- sec_reset_n is registered. It rises to 1 on the first edge with reset=1.
- States:
  - IDLE: busy=0.
  - WAIT_STB: busy=1.
  - FLUSH: busy=1.
- IDLE, cfg_we=1, cfg_sec<NSEC: write shadow[cfg_sec][cfg_idx] at this edge. Active bank and coef_out are unchanged.
- cfg_we=1 with cfg_sec≥NSEC, or cfg_we=1 while busy: write dropped, cfg_err=1 the next cycle.
- IDLE, cfg_commit=1: latch cfg_flush, go to WAIT_STB.
  - cfg_we and cfg_commit in the same IDLE cycle: the write lands and is included in the commit.
  - sample_en in the same cycle as the commit is ignored; the swap waits for a later strobe.
- cfg_commit while busy: ignored, cfg_err=1 the next cycle. There is no queuing.
- WAIT_STB, sample_en=1, at edge E: active←shadow for all sections; coef_out shows the new values the cycle after E.
  - Flush latched 0: go to IDLE; commit_done=1 and busy=0 in the cycle after E.
  - Flush latched 1: go to FLUSH; sec_reset_n=0 from the cycle after E; load the down-counter with FLUSH_CYC-1.
- FLUSH: the counter decrements each cycle. On the edge where it reads 0: sec_reset_n←1, state←IDLE, commit_done=1. sec_reset_n is low for exactly FLUSH_CYC cycles.
- sample_en during FLUSH is ignored by this block.
- commit_done and cfg_err are never asserted for more than one cycle. They can coincide (a rejected write on the final busy cycle).
- Reset mid-commit: the commit is abandoned, both banks are zeroed, and no commit_done is issued.
- Coefficients are raw 16-bit, treated as opaque. No arithmetic is performed here.

Decomposition:
- Shared package holds:
  - coefficient index constants IDX_A11=0, IDX_A21=1, IDX_B11=2, IDX_B21=3;
  - state encoding IDLE/WAIT_STB/FLUSH;
  - COEF_W=16.
- One sub-module, iir_coef_bank: shadow and active register arrays with write port, bulk-copy strobe and flattened output.
- The FSM, flush counter and error logic stay in iir_coef_ctrl.

Test Plan:
- Reset release: hold reset=0 for 5 cycles, then 1 → coef_out=0, busy=0; sec_reset_n=0 during reset, 1 from the first cycle after release.
- Write then commit (no flush): write sec0 idx0=16'h1234 and sec1 idx3=16'hABCD, commit with cfg_flush=0, sample_en 4 cycles later → coef_out unchanged until the strobe edge; next cycle coef_out[15:0]=16'h1234, coef_out[127:112]=16'hABCD, commit_done pulses once, busy falls.
- Flush commit: commit with cfg_flush=1, sample_en at edge E → sec_reset_n low for exactly 3 cycles after E; commit_done on the cycle sec_reset_n returns high.
- Rejects:
  - write with cfg_sec=1 while NSEC=1 → cfg_err pulses once, shadow unchanged;
  - cfg_commit and cfg_we while in WAIT_STB → each gives one cfg_err pulse; the original commit completes normally.
- Same-cycle write and commit: cfg_we (sec0 idx2=16'h00FF) with cfg_commit in IDLE, sample_en in that same cycle → no swap at that strobe; the next sample_en swaps, and the value 16'h00FF appears in coef_out[47:32].
- Reset mid-flush: reset=0 during the second FLUSH cycle → coef_out=0, no commit_done; after release, sec_reset_n=1 and state is IDLE.
